// File: rtl/mode_sched_pkg.sv
// Shared types and mode encodings for the mode scheduler and the mode/status
// control FSM it feeds.
package mode_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_A    = 2'b01;
    localparam logic [1:0] MODE_B    = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: returns the first eligible index after
// i_ptr (wrapping), so the entry at i_ptr itself has the lowest priority.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_eligible,
    input  logic [IDW-1:0] i_ptr,
    output logic [IDW-1:0] o_winner,
    output logic           o_any_valid
);

    int w_dist;
    int w_best_dist;

    // Distance 1..N from the pointer; the smallest eligible distance wins.
    always_comb begin
        o_winner    = '0;
        w_dist      = 0;
        w_best_dist = N + 1;
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(i_ptr);
            if (w_dist <= 0) begin
                w_dist = w_dist + N;
            end
            if (i_eligible[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_winner    = IDW'(i);
            end
        end
    end

    assign o_any_valid = |i_eligible;

endmodule

// File: rtl/mode_sched_arbiter.sv
// Round-robin owner of the shared 2-bit mode path: drives the winner's mode,
// waits a settle interval, grants, and holds until release or preemption.
module mode_sched_arbiter
    import mode_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int IDW           = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 16,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_mode,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDW-1:0]       owner_id,
    output logic [1:0]           mode_out,
    output logic                 busy,
    output logic                 preempt,
    output logic                 invalid_req
);

    localparam logic [IDW-1:0]   PTR_INIT    = IDW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDW-1:0]       r_owner_id;
    logic [1:0]           r_mode_out;
    logic                 r_busy;
    logic                 r_preempt;
    logic                 r_invalid;
    logic [IDW-1:0]       r_ptr;
    logic [CNT_W-1:0]     r_settle_cnt;
    logic [CNT_W-1:0]     r_hold_cnt;

    state_e               w_state_nx;
    logic [NUM_REQ-1:0]   w_grant_nx;
    logic [IDW-1:0]       w_owner_nx;
    logic [1:0]           w_mode_nx;
    logic                 w_busy_nx;
    logic                 w_preempt_nx;
    logic                 w_invalid_nx;
    logic [IDW-1:0]       w_ptr_nx;
    logic [CNT_W-1:0]     w_settle_nx;
    logic [CNT_W-1:0]     w_hold_nx;

    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_rsvd;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [NUM_REQ-1:0]   w_others;
    logic                 w_owner_req;
    logic [IDW-1:0]       w_winner;
    logic                 w_any;
    logic [1:0]           w_win_mode;

    // Reserved-mode requests never compete; they only raise invalid_req.
    always_comb begin
        w_elig = '0;
        w_rsvd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsvd[i] = req[i] && (req_mode[2*i +: 2] == MODE_RSVD);
            w_elig[i] = req[i] && (req_mode[2*i +: 2] != MODE_RSVD);
        end
    end

    assign w_owner_oh  = NUM_REQ'(1) << r_owner_id;
    assign w_others    = w_elig & ~w_owner_oh;
    assign w_owner_req = |(req & w_owner_oh);
    assign w_win_mode  = req_mode[{w_winner, 1'b0} +: 2];

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .i_eligible  (w_elig),
        .i_ptr       (r_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner_id   <= '0;
            r_mode_out   <= MODE_IDLE;
            r_busy       <= 1'b0;
            r_preempt    <= 1'b0;
            r_invalid    <= 1'b0;
            r_ptr        <= PTR_INIT;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_grant      <= w_grant_nx;
            r_owner_id   <= w_owner_nx;
            r_mode_out   <= w_mode_nx;
            r_busy       <= w_busy_nx;
            r_preempt    <= w_preempt_nx;
            r_invalid    <= w_invalid_nx;
            r_ptr        <= w_ptr_nx;
            r_settle_cnt <= w_settle_nx;
            r_hold_cnt   <= w_hold_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_owner_nx   = r_owner_id;
        w_mode_nx    = r_mode_out;
        w_preempt_nx = 1'b0;
        w_invalid_nx = 1'b0;
        w_ptr_nx     = r_ptr;
        w_settle_nx  = r_settle_cnt;
        w_hold_nx    = r_hold_cnt;
        case (r_state)
            IDLE: begin
                w_invalid_nx = |w_rsvd;
                if (w_any) begin
                    w_state_nx  = SETTLE;
                    w_owner_nx  = w_winner;
                    w_mode_nx   = w_win_mode;
                    w_ptr_nx    = w_winner;
                    w_settle_nx = SETTLE_INIT;
                end
            end
            SETTLE: begin
                // Abort wins over grant; the pointer keeps the aborted winner.
                if (!w_owner_req) begin
                    w_state_nx = IDLE;
                    w_owner_nx = '0;
                    w_mode_nx  = MODE_IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_state_nx = GRANT;
                    w_grant_nx = w_owner_oh;
                    w_hold_nx  = '0;
                end else begin
                    w_settle_nx = r_settle_cnt - CNT_W'(1);
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    w_state_nx = IDLE;
                    w_grant_nx = '0;
                    w_owner_nx = '0;
                    w_mode_nx  = MODE_IDLE;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && (|w_others)) begin
                    w_state_nx   = IDLE;
                    w_grant_nx   = '0;
                    w_owner_nx   = '0;
                    w_mode_nx    = MODE_IDLE;
                    w_preempt_nx = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nx = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = '0;
                w_owner_nx = '0;
                w_mode_nx  = MODE_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != IDLE);
    end

    assign grant       = r_grant;
    assign owner_id    = r_owner_id;
    assign mode_out    = r_mode_out;
    assign busy        = r_busy;
    assign preempt     = r_preempt;
    assign invalid_req = r_invalid;

endmodule

// File: tb/tb_mode_sched_arbiter.sv
// Scoreboard bench for mode_sched_arbiter: stimulus queues the expected sequence
// of output changes (with cycle spacing); a negedge monitor pops and compares.
module tb_mode_sched_arbiter;
    import mode_sched_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int IDW           = 2;
    localparam int SETTLE_CYCLES = 2;
    localparam int MAX_HOLD      = 16;
    localparam int CNT_W         = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [2*NUM_REQ-1:0] req_mode = '0;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       owner_id;
    logic [1:0]           mode_out;
    logic                 busy;
    logic                 preempt;
    logic                 invalid_req;

    mode_sched_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .IDW           (IDW),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MAX_HOLD      (MAX_HOLD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_mode    (req_mode),
        .grant       (grant),
        .owner_id    (owner_id),
        .mode_out    (mode_out),
        .busy        (busy),
        .preempt     (preempt),
        .invalid_req (invalid_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic [1:0] m;
        logic       b;
        logic       p;
        logic       iv;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dt;
    } exp_t;

    exp_t  q[$];
    exp_t  e_cur;
    snap_t cur;
    snap_t prev = '0;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_cyc = 0;
    logic  done = 1'b0;

    // dt = cycles since the previous output change; -1 = don't care.
    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic [1:0] m,
                        input logic b, input logic p, input logic iv, input int dt);
        exp_t e;
        e.s  = {g, id, m, b, p, iv};
        e.dt = dt;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req      = '0;
        req_mode = '0;
        rst      = 1'b1;
        tick(2);
        rst      = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        cur = {grant, owner_id, mode_out, busy, preempt, invalid_req};
        checks++;
        assert ($onehot0(grant)) else begin
            failures++;
            $display("FAIL grant_onehot0 cyc=%0d got=%b", cyc, grant);
        end
        if (rst) begin
            checks++;
            if (cur != '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, cur, 11'b0);
            end
            prev     = cur;
            last_cyc = cyc;
        end else if (cur != prev) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
                e_cur = q.pop_front();
                if ((cur != e_cur.s) || ((e_cur.dt >= 0) && ((cyc - last_cyc) != e_cur.dt))) begin
                    failures++;
                    $display("FAIL output_event cyc=%0d got=%b dt=%0d exp=%b dt=%0d",
                             cyc, cur, cyc - last_cyc, e_cur.s, e_cur.dt);
                end
            end
            prev     = cur;
            last_cyc = cyc;
        end
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                failures++;
                $display("FAIL missing_events got=%0d pending exp=0", q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #1;
        do_reset();

        // Single requester: mode after 1 edge, grant 2 edges later, release.
        push(4'b0000, 2'd0, MODE_A, 1, 0, 0, -1);
        push(4'b0001, 2'd0, MODE_A, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 2);
        req = 4'b0001; req_mode = {MODE_IDLE, MODE_IDLE, MODE_IDLE, MODE_A};
        tick(4); req = 4'b0000;
        tick(3);

        // Round-robin rotation, each owner holds 3 grant cycles; 0 re-queues behind 2,3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push(4'b0000, 2'(k % 4), MODE_B, 1, 0, 0, (k == 0) ? -1 : 1);
            push(4'(1 << (k % 4)), 2'(k % 4), MODE_B, 1, 0, 0, 2);
            push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 3);
        end
        req = 4'b1111; req_mode = {MODE_B, MODE_B, MODE_B, MODE_B};
        tick(5); req = 4'b1110;
        tick(6); req = 4'b1101;
        tick(6); req = 4'b1001;
        tick(6); req = 4'b0001;
        tick(6); req = 4'b0000;
        tick(3);

        // Preemption after 16 grant cycles, then settle abort of requester 1.
        do_reset();
        push(4'b0000, 2'd1, MODE_A, 1, 0, 0, -1);
        push(4'b0010, 2'd1, MODE_A, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 1, 0, 16);
        push(4'b0000, 2'd2, MODE_B, 1, 0, 0, 1);
        push(4'b0100, 2'd2, MODE_B, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 2);
        push(4'b0000, 2'd1, MODE_A, 1, 0, 0, 1);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 1);
        req = 4'b0010; req_mode = {MODE_IDLE, MODE_B, MODE_A, MODE_IDLE};
        tick(5); req = 4'b0110;
        tick(18); req = 4'b0010;
        tick(2); req = 4'b0000;
        tick(3);

        // Reserved mode is masked and flagged; requester 3 still wins.
        do_reset();
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 1, -1);
        push(4'b0000, 2'd3, MODE_B, 1, 0, 1, 3);
        push(4'b0000, 2'd3, MODE_B, 1, 0, 0, 1);
        push(4'b1000, 2'd3, MODE_B, 1, 0, 0, 1);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 2);
        req = 4'b0001; req_mode = {MODE_B, MODE_IDLE, MODE_IDLE, MODE_RSVD};
        tick(3); req = 4'b1001;
        tick(4); req = 4'b0000;
        tick(3);

        // Settle abort by owner 0; next search starts at 1, so 2 beats re-raised 0.
        do_reset();
        push(4'b0000, 2'd0, MODE_A, 1, 0, 0, -1);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 1);
        push(4'b0000, 2'd2, MODE_B, 1, 0, 0, 1);
        push(4'b0100, 2'd2, MODE_B, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 1);
        req = 4'b0101; req_mode = {MODE_IDLE, MODE_B, MODE_IDLE, MODE_A};
        tick(1); req = 4'b0100;
        tick(1); req = 4'b0101;
        tick(3); req = 4'b0000;
        tick(3);

        // Asynchronous reset mid-grant, then requester 0 has priority again.
        do_reset();
        push(4'b0000, 2'd1, MODE_B, 1, 0, 0, -1);
        push(4'b0010, 2'd1, MODE_B, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_A, 1, 0, 0, -1);
        push(4'b0001, 2'd0, MODE_A, 1, 0, 0, 2);
        push(4'b0000, 2'd0, MODE_IDLE, 0, 0, 0, 1);
        req = 4'b0010; req_mode = {MODE_IDLE, MODE_IDLE, MODE_B, MODE_IDLE};
        tick(4);
        #2 rst = 1'b1;
        tick(1);
        rst = 1'b0; req = 4'b0011; req_mode = {MODE_IDLE, MODE_IDLE, MODE_B, MODE_A};
        tick(3); req = 4'b0000;
        tick(3);

        done = 1'b1;
    end

endmodule
